// File: rtl/car_presence_detector_pkg.sv
// Shared definitions for the country-road car presence detector.
// The light codes are common with the highway/country signal controller.
package car_presence_detector_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // Queue update selected for the current cycle.
  typedef enum logic [1:0] {
    Q_HOLD  = 2'd0,
    Q_INC   = 2'd1,
    Q_DEC   = 2'd2,
    Q_FLUSH = 2'd3
  } q_op_e;

  // Code 2'd3 is deliberately not RED.
  function automatic logic is_red(input logic [1:0] code);
    return code == RED;
  endfunction

endpackage

// File: rtl/car_presence_detector_if.sv
// Sensor-side and controller-side signals of the car presence detector.
// master: roadside pins / signal controller side; slave: the detector.
interface car_presence_detector_if #(
  parameter int CNT_W = 4
);
  logic             arrive_raw;
  logic             depart_raw;
  logic [1:0]       cntry;
  logic             X;
  logic [CNT_W-1:0] queue_cnt;
  logic             overflow;
  logic             red_run;

  modport master (
    output arrive_raw, depart_raw, cntry,
    input  X, queue_cnt, overflow, red_run
  );

  modport slave (
    input  arrive_raw, depart_raw, cntry,
    output X, queue_cnt, overflow, red_run
  );
endinterface

// File: rtl/car_presence_detector_sig_debounce.sv
// Road-loop conditioning: 2-flop synchronizer, stability debouncer and
// a one-cycle pulse on each rising edge of the filtered level.
module sig_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clock,
  input  logic clear_n,
  input  logic raw_i,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          filt_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles that disagree with the filtered level; the
  // level flips on the DEBOUNCE_CYC-th such cycle, any agreement restarts.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_TC) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and edge-detect delay.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  assign rise_o = filt_q & ~filt_dly_q;

endmodule

// File: rtl/car_presence_detector.sv
// Country-road car presence detector: counts vehicles queued between the
// arrival loop and the exit loop and drives X while the queue is non-empty.
// Optional build macro STALE_FLUSH_EN adds a timer that empties a queue left
// stranded by missed exit-loop pulses during a long green.
module car_presence_detector
  import car_presence_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 4,
  parameter int MAX_CARS     = 15,
  parameter int FLUSH_CYC    = 1000
) (
  input  logic                  clock,
  input  logic                  clear_n,
  car_presence_detector_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_CARS);

  // Out-of-range parameters elaborate a visibly named marker block.
  if (DEBOUNCE_CYC < 1 || FLUSH_CYC < 1 || MAX_CARS > (2**CNT_W - 1)) begin : g_param_out_of_range
  end

  logic             arr_evt, dep_evt;
  logic             flush_hit;
  q_op_e            q_op;
  logic [CNT_W-1:0] queue_q, queue_d;
  logic             ovf_q, ovf_d;
  logic             red_run_q, red_run_d;

  sig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arrive (
    .clock   (clock),
    .clear_n (clear_n),
    .raw_i   (bus.arrive_raw),
    .rise_o  (arr_evt)
  );

  sig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_depart (
    .clock   (clock),
    .clear_n (clear_n),
    .raw_i   (bus.depart_raw),
    .rise_o  (dep_evt)
  );

`ifdef STALE_FLUSH_EN
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_TC = FW'(FLUSH_CYC - 1);

  logic          flush_run;
  logic [FW-1:0] flush_tmr_q, flush_tmr_d;

  // Down-counter over green cycles with cars waiting and nobody leaving.
  always_comb begin
    flush_run   = (bus.cntry == GREEN) && (queue_q != '0) && !dep_evt;
    flush_hit   = flush_run && (flush_tmr_q == '0);
    flush_tmr_d = (!flush_run || flush_hit) ? FLUSH_TC : flush_tmr_q - 1'b1;
  end

  // Flush timer register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      flush_tmr_q <= FLUSH_TC;
    end else begin
      flush_tmr_q <= flush_tmr_d;
    end
  end
`else
  assign flush_hit = 1'b0;
`endif

  // Choose the queue operation; coincident arrival and departure cancel.
  always_comb begin
    q_op = Q_HOLD;
    if (flush_hit) begin
      q_op = Q_FLUSH;
    end else if (arr_evt && !dep_evt) begin
      q_op = Q_INC;
    end else if (dep_evt && !arr_evt) begin
      q_op = Q_DEC;
    end
  end

  // Apply the operation with saturation at MAX_CARS and at zero.
  always_comb begin
    queue_d   = queue_q;
    ovf_d     = ovf_q;
    red_run_d = dep_evt && is_red(bus.cntry);
    case (q_op)
      Q_FLUSH: queue_d = arr_evt ? CNT_W'(1) : '0;
      Q_INC: begin
        if (queue_q == MAX_Q) ovf_d = 1'b1;
        else                  queue_d = queue_q + 1'b1;
      end
      Q_DEC: begin
        if (queue_q != '0) queue_d = queue_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Queue, sticky overflow and red-run pulse registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      queue_q   <= '0;
      ovf_q     <= 1'b0;
      red_run_q <= 1'b0;
    end else begin
      queue_q   <= queue_d;
      ovf_q     <= ovf_d;
      red_run_q <= red_run_d;
    end
  end

  assign bus.queue_cnt = queue_q;
  assign bus.X         = (queue_q != '0);
  assign bus.overflow  = ovf_q;
  assign bus.red_run   = red_run_q;

endmodule

// File: tb/tb_car_presence_detector.sv
// Scoreboard bench for car_presence_detector. Waveform plans are built per
// run, a pulse-level reference model turns them into the expected sequence
// of output changes, and a monitor pops one entry per observed change.
// Build with +define+STALE_FLUSH_EN to check the flush variant.
module tb_car_presence_detector;
  import car_presence_detector_pkg::*;

  localparam int D     = 4;
  localparam int CW    = 4;
  localparam int MAXQ  = 15;
  localparam int FL    = 20;
  localparam int MAXN  = 1000;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  car_presence_detector_if #(.CNT_W(CW)) bus();

  car_presence_detector #(
    .DEBOUNCE_CYC (D),
    .CNT_W        (CW),
    .MAX_CARS     (MAXQ),
    .FLUSH_CYC    (FL)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int cnt;
    bit ovf;
    bit rr;
  } exp_t;

  exp_t       sbq[$];
  bit         aw[MAXN];
  bit         dw[MAXN];
  logic [1:0] cw[MAXN];
  int         nc;
  int         cyc;
  bit         active;
  int         mdl_q;
  logic [5:0] mon_last;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_plan(input int n);
    nc = n;
    for (int i = 0; i < MAXN; i++) begin
      aw[i] = 1'b0;
      dw[i] = 1'b0;
      cw[i] = YELLOW;
    end
  endtask

  task automatic pulse(input bit is_arr, input int s, input int len);
    for (int i = s; i < s + len && i < nc; i++) begin
      if (is_arr) aw[i] = 1'b1;
      else        dw[i] = 1'b1;
    end
  endtask

  task automatic light(input int s, input int len, input logic [1:0] v);
    for (int i = s; i < s + len && i < nc; i++) cw[i] = v;
  endtask

  // Reference: a high run of at least D cycles starting in cycle s becomes an
  // event in cycle s+D+2 and shows on the outputs one cycle later.
  task automatic build_expect();
    bit aev[MAXN];
    bit dev[MAXN];
    int q, nq, run_f, len;
    bit ovf, novf, rr, nrr, flushed;
    for (int i = 0; i < MAXN; i++) begin
      aev[i] = 1'b0;
      dev[i] = 1'b0;
    end
    for (int k = 0; k < nc; k++) begin
      if (aw[k] && (k == 0 || !aw[k-1])) begin
        len = 0;
        while (k + len < nc && aw[k+len]) len++;
        if (len >= D && k + D + 2 < nc) aev[k+D+2] = 1'b1;
      end
      if (dw[k] && (k == 0 || !dw[k-1])) begin
        len = 0;
        while (k + len < nc && dw[k+len]) len++;
        if (len >= D && k + D + 2 < nc) dev[k+D+2] = 1'b1;
      end
    end
    sbq.delete();
    q = 0; ovf = 0; rr = 0; run_f = 0;
    for (int k = 0; k < nc - 1; k++) begin
      nq = q; novf = ovf; flushed = 0;
`ifdef STALE_FLUSH_EN
      if (cw[k] == GREEN && q != 0 && !dev[k]) run_f++;
      else run_f = 0;
      if (run_f == FL) begin
        run_f = 0;
        flushed = 1;
        nq = aev[k] ? 1 : 0;
      end
`endif
      if (!flushed) begin
        if (aev[k] && !dev[k]) begin
          if (q == MAXQ) novf = 1;
          else nq = q + 1;
        end else if (dev[k] && !aev[k] && q > 0) begin
          nq = q - 1;
        end
      end
      nrr = dev[k] && (cw[k] == RED);
      if (nq != q || novf != ovf || nrr != rr) sbq.push_back('{k + 1, nq, novf, nrr});
      q = nq; ovf = novf; rr = nrr;
    end
    mdl_q = q;
  endtask

  // Called just after a rising edge; plays cycle k inputs until the edge
  // that ends cycle nc-1.
  task automatic play();
    mon_last = '0;
    active   = 1'b1;
    for (int k = 0; k < nc; k++) begin
      cyc = k;
      bus.arrive_raw = aw[k];
      bus.depart_raw = dw[k];
      bus.cntry      = cw[k];
      @(posedge clock);
      #1;
    end
    active = 1'b0;
    check("sb_drained", sbq.size(), 0);
  endtask

  task automatic mid_reset();
    check("pre_reset_cnt", bus.queue_cnt, mdl_q);
    #2;
    clear_n = 1'b0;
    #1;
    check("rst_queue_cnt", bus.queue_cnt, 0);
    check("rst_X", bus.X, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_red_run", bus.red_run, 0);
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
  endtask

  // Monitor: every change of the observed outputs consumes one expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (active && {bus.queue_cnt, bus.overflow, bus.red_run} != mon_last) begin
        mon_last = {bus.queue_cnt, bus.overflow, bus.red_run};
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: cnt=%0d ovf=%0d rr=%0d, expected no change (cycle %0d)",
                   bus.queue_cnt, bus.overflow, bus.red_run, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("change_cycle", cyc, e.cyc);
          check("queue_cnt", bus.queue_cnt, e.cnt);
          check("overflow", bus.overflow, e.ovf);
          check("red_run", bus.red_run, e.rr);
          check("X", bus.X, (e.cnt != 0));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, len;
    active = 1'b0;
    cyc    = 0;
    bus.arrive_raw = 1'b0;
    bus.depart_raw = 1'b0;
    bus.cntry      = YELLOW;
    repeat (3) @(posedge clock);
    #1;
    check("por_queue_cnt", bus.queue_cnt, 0);
    check("por_X", bus.X, 0);
    check("por_overflow", bus.overflow, 0);
    check("por_red_run", bus.red_run, 0);
    clear_n = 1'b1;

    // Run 1: latency, glitch, saturation, drain on green, coincident events,
    // red-light departure, then a pulse left half-debounced.
    clear_plan(470);
    pulse(1, 2, 10);
    pulse(1, 20, 3);
    for (int i = 0; i < 15; i++) pulse(1, 30 + 10 * i, 5);
    light(185, 155, GREEN);
    for (int i = 0; i < 15; i++) pulse(0, 190 + 10 * i, 5);
    for (int i = 0; i < 3; i++) pulse(1, 350 + 10 * i, 5);
    pulse(1, 390, 6);
    pulse(0, 390, 6);
    light(405, 20, RED);
    pulse(0, 410, 5);
    for (int i = 0; i < 3; i++) pulse(1, 430 + 10 * i, 5);
    pulse(1, 468, 2);
    build_expect();
    play();
    mid_reset();

    // Run 2: sensor held through reset release, then a long car-less green.
    clear_plan(90);
    pulse(1, 0, 10);
    pulse(1, 20, 6);
    light(30, 50, GREEN);
    build_expect();
    play();
    mid_reset();

    // Run 3: random pulses, glitches and light codes.
    clear_plan(900);
    s = 2 + $urandom_range(0, 5);
    while (1) begin
      len = $urandom_range(1, 8);
      if (s + len + D + 4 >= nc - 10) break;
      pulse(1, s, len);
      s += len + $urandom_range(D, D + 8);
    end
    s = 2 + $urandom_range(0, 9);
    while (1) begin
      len = $urandom_range(1, 8);
      if (s + len + D + 4 >= nc - 10) break;
      pulse(0, s, len);
      s += len + $urandom_range(D, D + 10);
    end
    s = 0;
    while (s < nc) begin
      len = $urandom_range(3, 40);
      light(s, len, 2'($urandom_range(0, 3)));
      s += len;
    end
    build_expect();
    play();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
